i2c_reg_sequencer: RTL and testbench

Register-transaction sequencer that sits directly upstream of the I2C byte engine. It turns a single register write or burst register read request into the ordered START / WRITE / READ / STOP commands the engine executes, using the engine's enable/complete handshake. Read bytes are collected into a packed result word for the requester.

---
 rtl/i2c_reg_sequencer_if.sv | 25 ++
 rtl/i2c_reg_sequencer.sv | 174 +++++++++++++++++
 tb/tb_i2c_reg_sequencer.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_reg_sequencer_if.sv
// Sequencer <-> I2C byte engine command handshake bundle.
// master: drives instruction/enable/byte, slave: returns byte/complete.
interface i2c_reg_sequencer_if;
   logic [1:0] i2c_instruction_o;
   logic       i2c_enable_o;
   logic [7:0] i2c_byte_o;
   logic [7:0] i2c_byte_i;
   logic       i2c_complete_i;

   modport master (
      output i2c_instruction_o,
      output i2c_enable_o,
      output i2c_byte_o,
      input  i2c_byte_i,
      input  i2c_complete_i
   );

   modport slave (
      input  i2c_instruction_o,
      input  i2c_enable_o,
      input  i2c_byte_o,
      output i2c_byte_i,
      output i2c_complete_i
   );
endinterface

// File: rtl/i2c_reg_sequencer.sv
// Turns one register write / burst read request into I2C engine commands.
// Ports: clk_i, rst_ni (sync, low), req/rw/dev/reg/wdata/len request in,
// busy_o, done_o, rdata_o result out, eng = engine command handshake.
module i2c_reg_sequencer #(
   parameter int unsigned BurstWidth = 2
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            req_i,
   input  logic                            rw_i,
   input  logic [6:0]                      dev_addr_i,
   input  logic [7:0]                      reg_addr_i,
   input  logic [7:0]                      wdata_i,
   input  logic [BurstWidth-1:0]           len_i,
   output logic                            busy_o,
   output logic                            done_o,
   output logic [8*(2**BurstWidth)-1:0]    rdata_o,
   i2c_reg_sequencer_if.master             eng
);

   localparam int unsigned DW = 8 * (2**BurstWidth);

   localparam logic [1:0] I_START = 2'b00;
   localparam logic [1:0] I_STOP  = 2'b01;
   localparam logic [1:0] I_READ  = 2'b10;
   localparam logic [1:0] I_WRITE = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_ARM, S_WAIT, S_RELEASE, S_FINISH
   } state_e;

   typedef enum logic [2:0] {
      P_START, P_DEV_W, P_REG, P_DATA,
      P_RESTART, P_DEV_R, P_READ, P_STOP
   } step_e;

   state_e              state_q, state_d;
   step_e               step_q, step_d;
   logic                rw_q, rw_d;
   logic [6:0]          dev_q, dev_d;
   logic [7:0]          reg_q, reg_d;
   logic [7:0]          wdata_q, wdata_d;
   logic [BurstWidth-1:0] len_q, len_d;
   logic [BurstWidth:0] k_q, k_d;
   logic [DW-1:0]       rdata_q, rdata_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                en_q, en_d;
   logic [1:0]          ins_q, ins_d;
   logic [7:0]          byte_q, byte_d;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         step_q  <= P_START;
         rw_q    <= 1'b0;
         dev_q   <= '0;
         reg_q   <= '0;
         wdata_q <= '0;
         len_q   <= '0;
         k_q     <= '0;
         rdata_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         en_q    <= 1'b0;
         ins_q   <= I_START;
         byte_q  <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         rw_q    <= rw_d;
         dev_q   <= dev_d;
         reg_q   <= reg_d;
         wdata_q <= wdata_d;
         len_q   <= len_d;
         k_q     <= k_d;
         rdata_q <= rdata_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         en_q    <= en_d;
         ins_q   <= ins_d;
         byte_q  <= byte_d;
      end
   end

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      rw_d    = rw_q;
      dev_d   = dev_q;
      reg_d   = reg_q;
      wdata_d = wdata_q;
      len_d   = len_q;
      k_d     = k_q;
      rdata_d = rdata_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      en_d    = en_q;
      ins_d   = ins_q;
      byte_d  = byte_q;
      unique case (state_q)
         S_IDLE: begin
            if (req_i) begin
               rw_d    = rw_i;
               dev_d   = dev_addr_i;
               reg_d   = reg_addr_i;
               wdata_d = wdata_i;
               len_d   = len_i;
               k_d     = '0;
               busy_d  = 1'b1;
               step_d  = P_START;
               state_d = S_ISSUE;
               if (rw_i) rdata_d = '0;
            end
         end
         S_ISSUE: begin
            en_d    = 1'b1;
            state_d = S_ARM;
            unique case (step_q)
               P_START,
               P_RESTART: begin ins_d = I_START; byte_d = '0; end
               P_DEV_W: begin ins_d = I_WRITE; byte_d = {dev_q, 1'b0}; end
               P_REG:   begin ins_d = I_WRITE; byte_d = reg_q; end
               P_DATA:  begin ins_d = I_WRITE; byte_d = wdata_q; end
               P_DEV_R: begin ins_d = I_WRITE; byte_d = {dev_q, 1'b1}; end
               P_READ:  begin ins_d = I_READ;  byte_d = '0; end
               P_STOP:  begin ins_d = I_STOP;  byte_d = '0; end
            endcase
         end
         // Engine still shows the previous command's complete here.
         S_ARM: state_d = S_WAIT;
         S_WAIT: begin
            if (eng.i2c_complete_i) begin
               en_d    = 1'b0;
               state_d = S_RELEASE;
               if (step_q == P_READ) begin
                  rdata_d[{k_q[BurstWidth-1:0], 3'b000} +: 8] =
                     eng.i2c_byte_i;
                  k_d = k_q + 1'b1;
               end
            end
         end
         S_RELEASE: begin
            state_d = S_ISSUE;
            unique case (step_q)
               P_START:   step_d = P_DEV_W;
               P_DEV_W:   step_d = P_REG;
               P_REG:     step_d = rw_q ? P_RESTART : P_DATA;
               P_DATA:    step_d = P_STOP;
               P_RESTART: step_d = P_DEV_R;
               P_DEV_R:   step_d = P_READ;
               P_READ: begin
                  if (k_q == ({1'b0, len_q} + 1'b1)) step_d = P_STOP;
               end
               P_STOP: begin
                  state_d = S_FINISH;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
               end
            endcase
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   assign busy_o                = busy_q;
   assign done_o                = done_q;
   assign rdata_o               = rdata_q;
   assign eng.i2c_enable_o      = en_q;
   assign eng.i2c_instruction_o = ins_q;
   assign eng.i2c_byte_o        = byte_q;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Self-checking bench for i2c_reg_sequencer with an engine model
// that holds a stale complete until it accepts each command.
module tb_i2c_reg_sequencer;

   typedef struct packed {
      logic [1:0] ins;
      logic [7:0] b;
   } cmd_t;

   typedef struct {
      logic        rw;
      logic [6:0]  dev;
      logic [7:0]  ra;
      logic [7:0]  wd;
      logic [1:0]  ln;
      logic [31:0] data;
      logic        poke;
      logic [31:0] exp_rd;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req = 1'b0;
   logic        rw = 1'b0;
   logic [6:0]  dev = '0;
   logic [7:0]  ra = '0;
   logic [7:0]  wd = '0;
   logic [1:0]  ln = '0;
   logic        busy;
   logic        done;
   logic [31:0] rdata;

   int n_chk = 0;
   int n_fail = 0;
   int done_cnt = 0;
   logic [31:0] last_rd = '0;

   cmd_t       log_q[$];
   logic [7:0] rd_src[$];

   i2c_reg_sequencer_if bus ();

   i2c_reg_sequencer #(.BurstWidth(2)) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .req_i      (req),
      .rw_i       (rw),
      .dev_addr_i (dev),
      .reg_addr_i (ra),
      .wdata_i    (wd),
      .len_i      (ln),
      .busy_o     (busy),
      .done_o     (done),
      .rdata_o    (rdata),
      .eng        (bus)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Engine model: accepts on first edge it sees enable, then
   // completes after a random delay and waits for enable low.
   int e_st = 0;
   int e_cnt = 0;
   always @(posedge clk) begin
      if (!rst_n) begin
         e_st <= 0;
         bus.i2c_complete_i <= 1'b1;
         bus.i2c_byte_i <= 8'h00;
      end else begin
         case (e_st)
            0: if (bus.i2c_enable_o) begin
               log_q.push_back({bus.i2c_instruction_o, bus.i2c_byte_o});
               bus.i2c_complete_i <= 1'b0;
               e_cnt <= $urandom_range(0, 3);
               e_st <= 1;
            end
            1: if (e_cnt == 0) begin
               bus.i2c_complete_i <= 1'b1;
               if (bus.i2c_instruction_o == 2'b10) begin
                  if (rd_src.size() > 0)
                     bus.i2c_byte_i <= rd_src.pop_front();
                  else
                     bus.i2c_byte_i <= 8'($urandom);
               end
               e_st <= 2;
            end else begin
               e_cnt <= e_cnt - 1;
            end
            default: if (!bus.i2c_enable_o) e_st <= 0;
         endcase
      end
   end

   // Handshake monitor: enable gap and command stability.
   logic       prev_en = 1'b0;
   int         low_cnt = 0;
   bit         seen_step = 1'b0;
   logic [1:0] hold_ins = '0;
   logic [7:0] hold_b = '0;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_en = 1'b0;
         low_cnt = 0;
         seen_step = 1'b0;
      end else begin
         if (done) done_cnt++;
         if (bus.i2c_enable_o && !prev_en) begin
            if (seen_step) chk("en_gap", low_cnt, 2);
            hold_ins = bus.i2c_instruction_o;
            hold_b = bus.i2c_byte_o;
            seen_step = 1'b1;
         end else if (bus.i2c_enable_o) begin
            chk("ins_stable", bus.i2c_instruction_o, hold_ins);
            chk("byte_stable", bus.i2c_byte_o, hold_b);
         end
         if (bus.i2c_enable_o) low_cnt = 0;
         else low_cnt++;
         if (done) seen_step = 1'b0;
         prev_en = bus.i2c_enable_o;
      end
   end

   function automatic logic [31:0] model_rd(input logic [1:0] l,
                                            input logic [31:0] d);
      logic [31:0] r;
      r = '0;
      for (int k = 0; k <= int'(l); k++) r[8*k +: 8] = d[8*k +: 8];
      return r;
   endfunction

   task automatic run_txn(input vec_t v, input string nm);
      cmd_t exp_q[$];
      int   d0;
      bit   got;
      bit   drop;
      int   bad;
      exp_q.push_back({2'b00, 8'h00});
      exp_q.push_back({2'b11, v.dev, 1'b0});
      exp_q.push_back({2'b11, v.ra});
      if (!v.rw) begin
         exp_q.push_back({2'b11, v.wd});
      end else begin
         exp_q.push_back({2'b00, 8'h00});
         exp_q.push_back({2'b11, v.dev, 1'b1});
         for (int k = 0; k <= int'(v.ln); k++) begin
            exp_q.push_back({2'b10, 8'h00});
            rd_src.push_back(v.data[8*k +: 8]);
         end
      end
      exp_q.push_back({2'b01, 8'h00});
      log_q.delete();
      @(negedge clk);
      req = 1'b1; rw = v.rw; dev = v.dev;
      ra = v.ra; wd = v.wd; ln = v.ln;
      @(posedge clk); #1;
      chk({nm, "_busy_rise"}, busy, 1);
      chk({nm, "_en_t"}, bus.i2c_enable_o, 0);
      @(negedge clk);
      req = 1'b0;
      @(posedge clk); #1;
      chk({nm, "_en_t1"}, bus.i2c_enable_o, 1);
      d0 = done_cnt;
      got = 1'b0;
      drop = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (v.poke && c == 20) begin
            req = 1'b1; rw = ~v.rw; dev = 7'($urandom);
            ra = 8'($urandom); wd = 8'($urandom); ln = 2'($urandom);
         end else begin
            req = 1'b0;
         end
         if (done) begin got = 1'b1; break; end
         if (!busy) drop = 1'b1;
      end
      req = 1'b0;
      chk({nm, "_done_seen"}, got, 1);
      chk({nm, "_busy_held"}, drop, 0);
      chk({nm, "_busy_fall"}, busy, 0);
      chk({nm, "_rdata"}, rdata, v.exp_rd);
      repeat (2) @(negedge clk);
      chk({nm, "_done_pulses"}, done_cnt - d0, 1);
      chk({nm, "_cmd_count"}, log_q.size(), exp_q.size());
      bad = -1;
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
         if (bad < 0) begin
            if (log_q[i].ins !== exp_q[i].ins) bad = i;
            else if (exp_q[i].ins == 2'b11 && log_q[i].b !== exp_q[i].b)
               bad = i;
         end
      end
      if (bad >= 0)
         chk({nm, "_cmd_seq"}, {22'd0, log_q[bad]}, {22'd0, exp_q[bad]});
      else
         chk({nm, "_cmd_seq"}, 0, 0);
      if (v.rw) last_rd = v.exp_rd;
   endtask

   vec_t tbl[5];
   vec_t rv;
   int   nreads;
   bit   hit;

   initial begin
      tbl[0] = '{1'b0, 7'h3C, 8'h10, 8'hA5, 2'd0, 32'h0, 1'b0, 32'h0};
      tbl[1] = '{1'b1, 7'h50, 8'h02, 8'h00, 2'd0,
                 32'h0000005A, 1'b0, 32'h0000005A};
      tbl[2] = '{1'b1, 7'h50, 8'h20, 8'h00, 2'd3,
                 32'h44332211, 1'b0, 32'h44332211};
      tbl[3] = '{1'b0, 7'h12, 8'h34, 8'h56, 2'd0, 32'h0, 1'b1,
                 32'h44332211};
      tbl[4] = '{1'b1, 7'h7F, 8'hFF, 8'h00, 2'd1,
                 32'hDEADBEEF, 1'b1, 32'h0000BEEF};

      // Reset with a simultaneous request: reset must win.
      repeat (2) @(negedge clk);
      req = 1'b1;
      @(posedge clk); #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_en", bus.i2c_enable_o, 0);
      chk("rst_ins", bus.i2c_instruction_o, 0);
      chk("rst_byte", bus.i2c_byte_o, 0);
      @(negedge clk);
      req = 1'b0;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 5; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));

      for (int i = 0; i < 10; i++) begin
         rv.rw = 1'($urandom);
         rv.dev = 7'($urandom);
         rv.ra = 8'($urandom);
         rv.wd = 8'($urandom);
         rv.ln = 2'($urandom);
         rv.data = $urandom;
         rv.poke = (i % 3 == 0);
         rv.exp_rd = rv.rw ? model_rd(rv.ln, rv.data) : last_rd;
         run_txn(rv, $sformatf("rnd%0d", i));
      end

      // Reset during the second READ of a 4-byte burst.
      log_q.delete();
      rd_src.delete();
      @(negedge clk);
      req = 1'b1; rw = 1'b1; dev = 7'h21; ra = 8'h40; ln = 2'd3;
      @(negedge clk);
      req = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         nreads = 0;
         foreach (log_q[j]) if (log_q[j].ins == 2'b10) nreads++;
         if (nreads == 2) begin hit = 1'b1; break; end
         @(negedge clk);
      end
      chk("mid_second_read", hit, 1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_rdata", rdata, 0);
      chk("mid_rst_en", bus.i2c_enable_o, 0);
      chk("mid_rst_ins", bus.i2c_instruction_o, 0);
      chk("mid_rst_byte", bus.i2c_byte_o, 0);
      @(negedge clk);
      rst_n = 1'b1;
      rd_src.delete();
      last_rd = '0;
      repeat (2) @(negedge clk);
      rv = '{1'b0, 7'h3C, 8'h10, 8'hA5, 2'd0, 32'h0, 1'b0, 32'h0};
      run_txn(rv, "post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
